// File: rtl/motor_cmd_ramp_if.sv
// motor_cmd_ramp_if
//   Bundles the switch input and the drive-side outputs of motor_cmd_ramp.
//   master : the side that owns the switches and reads the commands (board/bench)
//   slave  : motor_cmd_ramp itself
//   Signals:
//     sw[7:0]   raw asynchronous speed/direction switches, active high
//     duty[3:0] commanded PWM slots out of 10 (0..10)
//     dir_fwd   current direction, 1 = forward
//     in_a/in_b L298 IN1/IN2
//     busy      reversal in progress (ramping down or dwelling)
//     multi_sw  accepted switch vector has more than one bit set
interface motor_cmd_ramp_if;
   logic [7:0] sw;
   logic [3:0] duty;
   logic       dir_fwd;
   logic       in_a;
   logic       in_b;
   logic       busy;
   logic       multi_sw;

   modport master (output sw, input duty, dir_fwd, in_a, in_b, busy, multi_sw);
   modport slave  (input sw, output duty, dir_fwd, in_a, in_b, busy, multi_sw);
endinterface

// File: rtl/motor_cmd_ramp.sv
// motor_cmd_ramp
//   Command front-end for a single L298-driven motor. Synchronises and
//   debounces eight switches, decodes them to a target duty (0..10) plus
//   direction, and slews the commanded duty toward the target one step per
//   ramp tick. A direction reversal ramps to zero, dwells, then flips.
//   Ports:
//     clk  system clock
//     rst  synchronous reset, active high
//     bus  motor_cmd_ramp_if.slave (sw in; duty, dir_fwd, in_a, in_b,
//          busy, multi_sw out)
//   Optional build macro:
//     MOTOR_CMD_BRAKE_EN  drive in_a = in_b = 1 (fast brake) during the dwell
//                         instead of coasting.
module motor_cmd_ramp #(
   parameter int unsigned DEBOUNCE_CYCLES  = 1_000_000,
   parameter int unsigned RAMP_STEP_CYCLES = 5_000_000,
   parameter int unsigned DWELL_CYCLES     = 20_000_000
) (
   input logic             clk,
   input logic             rst,
   motor_cmd_ramp_if.slave bus
);
   localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int unsigned RS_W = $clog2(RAMP_STEP_CYCLES + 1);
   localparam int unsigned DW_W = $clog2(DWELL_CYCLES + 1);

   typedef enum logic [1:0] {S_RUN, S_REV_DOWN, S_DWELL} state_t;

   logic [7:0]      sync1, sync2, sw_db;
   logic [DB_W-1:0] db_cnt;
   logic [RS_W-1:0] pre_cnt;
   logic            tick;
   logic [3:0]      dec_duty, tgt_duty;
   logic            dec_fwd, tgt_fwd;

   state_t          state, state_nxt;
   logic [3:0]      duty, duty_nxt;
   logic            dir_fwd, dir_nxt;
   logic [DW_W-1:0] dwell_cnt, dwell_nxt;
   logic            in_a, in_b, busy;
   logic            in_a_nxt, in_b_nxt, busy_nxt;

   // Input path. A difference between the two synchroniser stages means the
   // synchronised vector changes on this edge, so the counter restarts here.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1  <= '0;
         sync2  <= '0;
         sw_db  <= '0;
         db_cnt <= '0;
      end else begin
         sync1 <= bus.sw;
         sync2 <= sync1;
         if (sync1 != sync2)
            db_cnt <= '0;
         else if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1))
            sw_db <= sync2;
         else
            db_cnt <= db_cnt + 1'b1;
      end
   end

   // Highest set index wins; with nothing set the target keeps the current
   // direction so an idle switch bank never provokes a reversal.
   always_comb begin
      dec_duty = 4'd0;
      dec_fwd  = dir_fwd;
      if      (sw_db[7]) begin dec_duty = 4'd3;  dec_fwd = 1'b0; end
      else if (sw_db[6]) begin dec_duty = 4'd5;  dec_fwd = 1'b0; end
      else if (sw_db[5]) begin dec_duty = 4'd7;  dec_fwd = 1'b0; end
      else if (sw_db[4]) begin dec_duty = 4'd10; dec_fwd = 1'b0; end
      else if (sw_db[3]) begin dec_duty = 4'd3;  dec_fwd = 1'b1; end
      else if (sw_db[2]) begin dec_duty = 4'd5;  dec_fwd = 1'b1; end
      else if (sw_db[1]) begin dec_duty = 4'd7;  dec_fwd = 1'b1; end
      else if (sw_db[0]) begin dec_duty = 4'd10; dec_fwd = 1'b1; end
   end

   assign tick = (pre_cnt == RS_W'(RAMP_STEP_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         tgt_duty <= '0;
         tgt_fwd  <= 1'b1;
         pre_cnt  <= '0;
      end else begin
         tgt_duty <= dec_duty;
         tgt_fwd  <= dec_fwd;
         pre_cnt  <= tick ? '0 : pre_cnt + 1'b1;
      end
   end

   // State register; the pin/busy outputs are registered alongside so they
   // always describe the state that is current.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_RUN;
         duty      <= '0;
         dir_fwd   <= 1'b1;
         dwell_cnt <= '0;
         in_a      <= 1'b0;
         in_b      <= 1'b0;
         busy      <= 1'b0;
      end else begin
         state     <= state_nxt;
         duty      <= duty_nxt;
         dir_fwd   <= dir_nxt;
         dwell_cnt <= dwell_nxt;
         in_a      <= in_a_nxt;
         in_b      <= in_b_nxt;
         busy      <= busy_nxt;
      end
   end

   // Next state. Target is at most 10, so stepping toward it can never leave 0..10.
   always_comb begin
      state_nxt = state;
      duty_nxt  = duty;
      dir_nxt   = dir_fwd;
      dwell_nxt = dwell_cnt;
      case (state)
         S_RUN: begin
            if (tgt_duty != 4'd0 && tgt_fwd != dir_fwd) begin
               if (duty == 4'd0) begin
                  state_nxt = S_DWELL;
                  dwell_nxt = '0;
               end else begin
                  state_nxt = S_REV_DOWN;
               end
            end else if (tick) begin
               if (duty < tgt_duty)      duty_nxt = duty + 4'd1;
               else if (duty > tgt_duty) duty_nxt = duty - 4'd1;
            end
         end
         S_REV_DOWN: begin
            if (tgt_fwd == dir_fwd) begin
               state_nxt = S_RUN;
            end else if (duty == 4'd0) begin
               state_nxt = S_DWELL;
               dwell_nxt = '0;
            end else if (tick) begin
               duty_nxt = duty - 4'd1;
            end
         end
         S_DWELL: begin
            if (dwell_cnt == DW_W'(DWELL_CYCLES - 1)) begin
               state_nxt = S_RUN;
               if (tgt_duty != 4'd0) dir_nxt = tgt_fwd;
            end else begin
               dwell_nxt = dwell_cnt + 1'b1;
            end
         end
         default: state_nxt = S_RUN;
      endcase
   end

   // Outputs for the upcoming state; dec_duty is the target that will be
   // registered on the same edge.
   always_comb begin
      in_a_nxt = 1'b0;
      in_b_nxt = 1'b0;
      busy_nxt = (state_nxt != S_RUN);
      case (state_nxt)
         S_RUN: begin
            if (duty_nxt != 4'd0 || dec_duty != 4'd0) begin
               in_a_nxt = dir_nxt;
               in_b_nxt = ~dir_nxt;
            end
         end
         S_REV_DOWN: begin
            if (duty_nxt != 4'd0) begin
               in_a_nxt = dir_nxt;
               in_b_nxt = ~dir_nxt;
            end
         end
         S_DWELL: begin
`ifdef MOTOR_CMD_BRAKE_EN
            in_a_nxt = 1'b1;
            in_b_nxt = 1'b1;
`else
            in_a_nxt = 1'b0;
            in_b_nxt = 1'b0;
`endif
         end
         default: begin
            in_a_nxt = 1'b0;
            in_b_nxt = 1'b0;
         end
      endcase
   end

   assign bus.duty     = duty;
   assign bus.dir_fwd  = dir_fwd;
   assign bus.in_a     = in_a;
   assign bus.in_b     = in_b;
   assign bus.busy     = busy;
   // More than one bit set <=> clearing the lowest set bit leaves something.
   assign bus.multi_sw = ((sw_db & (sw_db - 8'd1)) != 8'd0);
endmodule

// File: tb/tb_motor_cmd_ramp.sv
module tb_motor_cmd_ramp;
   localparam int DEB = 4;
   localparam int RS  = 3;
   localparam int DW  = 5;
   localparam int M_RUN = 0, M_DOWN = 1, M_DWELL = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   motor_cmd_ramp_if bus ();

   motor_cmd_ramp #(
      .DEBOUNCE_CYCLES (DEB),
      .RAMP_STEP_CYCLES(RS),
      .DWELL_CYCLES    (DW)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.slave)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic to_chk(input string name, input int t, input int lim);
      checks++;
      if (t >= lim) begin
         errors++;
         $display("FAIL %s: timeout after %0d cycles, expected < %0d", name, t, lim);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [7:0] m_hist[$];   // m_hist[k-1] = sw sampled at edge k since reset
   int         m_n;
   logic [7:0] m_db;
   int         m_tgt;
   bit         m_tfwd;
   int         m_pre;
   int         m_duty;
   bit         m_dir;
   int         m_mode;
   int         m_dw_start;
   bit         m_ok = 1'b0;
   bit         tk, o_tfwd, o_dir, stable;
   int         o_tgt;

   function automatic int dec_duty(logic [7:0] v);
      int tbl[8];
      tbl = '{10, 7, 5, 3, 10, 7, 5, 3};
      for (int i = 7; i >= 0; i--) if (v[i]) return tbl[i];
      return 0;
   endfunction

   function automatic bit dec_fwd(logic [7:0] v, bit cur);
      for (int i = 7; i >= 0; i--) if (v[i]) return (i < 4);
      return cur;
   endfunction

   function automatic logic [7:0] s_at(int k);
      if (k < 1) return 8'h00;
      return m_hist[k-1];
   endfunction

   function automatic logic [1:0] exp_pins(int mode, int duty, bit dir, int tgt);
      if (mode == M_RUN)  return (duty > 0 || tgt > 0) ? {dir, ~dir} : 2'b00;
      if (mode == M_DOWN) return (duty > 0) ? {dir, ~dir} : 2'b00;
`ifdef MOTOR_CMD_BRAKE_EN
      return 2'b11;
`else
      return 2'b00;
`endif
   endfunction

   initial forever begin
      @(posedge clk);
      if (rst) begin
         m_hist.delete();
         m_n = 0; m_db = 8'h00; m_tgt = 0; m_tfwd = 1'b1; m_pre = 0;
         m_duty = 0; m_dir = 1'b1; m_mode = M_RUN; m_dw_start = 0;
         m_ok = 1'b1;
      end else begin
         tk     = (m_pre == RS - 1);
         m_pre  = tk ? 0 : m_pre + 1;
         o_tgt  = m_tgt;
         o_tfwd = m_tfwd;
         o_dir  = m_dir;
         m_tgt  = dec_duty(m_db);
         m_tfwd = dec_fwd(m_db, o_dir);
         m_n++;
         case (m_mode)
            M_RUN: begin
               if (o_tgt > 0 && o_tfwd != o_dir) begin
                  if (m_duty == 0) begin m_mode = M_DWELL; m_dw_start = m_n; end
                  else m_mode = M_DOWN;
               end else if (tk) begin
                  if (m_duty < o_tgt) m_duty++;
                  else if (m_duty > o_tgt) m_duty--;
               end
            end
            M_DOWN: begin
               if (o_tfwd == o_dir) m_mode = M_RUN;
               else if (m_duty == 0) begin m_mode = M_DWELL; m_dw_start = m_n; end
               else if (tk) m_duty--;
            end
            default: begin
               if (m_n - m_dw_start == DW) begin
                  m_mode = M_RUN;
                  if (o_tgt > 0) m_dir = o_tfwd;
               end
            end
         endcase
         // Accept the synchronised vector once it has held for DEB edges.
         stable = (m_n >= DEB);
         for (int k = m_n - 1 - DEB; k < m_n - 1; k++)
            if (s_at(k) != s_at(m_n - 1)) stable = 1'b0;
         if (stable) m_db = s_at(m_n - 1);
         m_hist.push_back(bus.sw);
      end
   end

   // Compare process: every cycle after the first reset edge.
   initial forever begin
      @(negedge clk);
      if (m_ok) begin
         chk("duty",     bus.duty,     m_duty);
         chk("dir_fwd",  bus.dir_fwd,  m_dir);
         chk("in_a",     bus.in_a,     exp_pins(m_mode, m_duty, m_dir, m_tgt) >> 1);
         chk("in_b",     bus.in_b,     exp_pins(m_mode, m_duty, m_dir, m_tgt) & 2'b01);
         chk("busy",     bus.busy,     m_mode != M_RUN);
         chk("multi_sw", bus.multi_sw, ((m_db & (m_db - 8'd1)) != 0));
      end
   end

   // ---------------- directed stimulus ----------------
   int t, zc, mind;

   initial begin
      bus.sw = 8'h00;
      rst    = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_duty", bus.duty, 0);
      chk("rst_dir",  bus.dir_fwd, 1);
      chk("rst_in_a", bus.in_a, 0);
      chk("rst_in_b", bus.in_b, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_multi", bus.multi_sw, 0);

      // Forward full-scale ramp: first tick after target lands is edge 9.
      rst    = 1'b0;
      bus.sw = 8'h01;
      repeat (8) @(negedge clk);
      chk("lat_e8_duty", bus.duty, 0);
      @(negedge clk);
      chk("lat_e9_duty", bus.duty, 1);
      repeat (26) @(negedge clk);
      chk("ramp_e35_duty", bus.duty, 9);
      @(negedge clk);
      chk("ramp_e36_duty", bus.duty, 10);
      chk("ramp_in_a", bus.in_a, 1);
      chk("ramp_in_b", bus.in_b, 0);

      // Bouncing input never holds long enough to be accepted.
      for (int i = 0; i < 20; i++) begin
         bus.sw = i[0] ? 8'h01 : 8'h00;
         repeat (2) @(negedge clk);
      end
      repeat (10) @(negedge clk);
      chk("bounce_duty", bus.duty, 10);

      // Reversal 10 fwd -> 7 rev.
      bus.sw = 8'h20;
      t = 0; while (!bus.busy && t < 50) begin @(negedge clk); t++; end
      to_chk("rev_busy_rise", t, 50);
      zc = 0; t = 0;
      while (bus.busy && t < 200) begin
         if (bus.duty == 0) zc++;
         @(negedge clk); t++;
      end
      to_chk("rev_busy_fall", t, 200);
      chk("rev_zero_cycles", zc, DW + 1);
      t = 0; while (bus.duty != 7 && t < 100) begin @(negedge clk); t++; end
      to_chk("rev_reach7", t, 100);
      chk("rev_dir", bus.dir_fwd, 0);
      chk("rev_in_a", bus.in_a, 0);
      chk("rev_in_b", bus.in_b, 1);
      chk("rev_busy", bus.busy, 0);

      // Back to 10 fwd, then abort a reversal midway.
      bus.sw = 8'h01;
      t = 0; while (!(bus.dir_fwd && bus.duty == 10) && t < 300) begin @(negedge clk); t++; end
      to_chk("fwd10", t, 300);
      bus.sw = 8'h20;
      t = 0; while (!(bus.busy && bus.duty == 8) && t < 100) begin @(negedge clk); t++; end
      to_chk("abort_at8", t, 100);
      bus.sw = 8'h02;
      mind = 10; t = 0;
      while (bus.busy && t < 100) begin
         if (bus.duty < mind) mind = bus.duty;
         @(negedge clk); t++;
      end
      to_chk("abort_busy_fall", t, 100);
      chk("abort_no_dwell", mind > 0, 1);
      t = 0; while (bus.duty != 7 && t < 100) begin @(negedge clk); t++; end
      to_chk("abort_reach7", t, 100);
      chk("abort_dir", bus.dir_fwd, 1);

      // Two switches: sw7 wins -> 3 reverse.
      bus.sw = 8'h88;
      t = 0; while (!bus.multi_sw && t < 30) begin @(negedge clk); t++; end
      to_chk("multi_rise", t, 30);
      t = 0; while (!bus.busy && t < 30) begin @(negedge clk); t++; end
      to_chk("multi_busy_rise", t, 30);
      t = 0; while (!(!bus.busy && bus.duty == 3) && t < 300) begin @(negedge clk); t++; end
      to_chk("multi_reach3", t, 300);
      chk("multi_dir", bus.dir_fwd, 0);
      chk("multi_in_a", bus.in_a, 0);
      chk("multi_in_b", bus.in_b, 1);

      // Reset in the middle of a ramp.
      bus.sw = 8'h01;
      t = 0; while (!(bus.dir_fwd && bus.duty == 4) && t < 300) begin @(negedge clk); t++; end
      to_chk("mid_reach4", t, 300);
      rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_duty", bus.duty, 0);
      chk("mid_rst_dir",  bus.dir_fwd, 1);
      chk("mid_rst_in_a", bus.in_a, 0);
      chk("mid_rst_busy", bus.busy, 0);
      chk("mid_rst_multi", bus.multi_sw, 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (30) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
